// File: rtl/ft_rx_fsm.sv
// ft_rx_fsm: FT600 245-sync RX FSM draining the chip FIFO into a valid/ready stream; define RX_PATTERN_CHECK_EN for err_cnt
module ft_rx_fsm #(
    parameter int DATA_W      = 8,
    parameter int BE_W        = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_MARGIN = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxf_n,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [BE_W-1:0]               be_in,
    output logic                          oe_n,
    output logic                          rd_n,
    output logic [DATA_W-1:0]             m_data,
    output logic [BE_W-1:0]               m_be,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
`ifdef RX_PATTERN_CHECK_EN
    output logic [15:0]                   err_cnt,
`endif
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, OE, READ} state_t;
    state_t state, state_nx;
    logic [DATA_W+BE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] free;
    logic push_q, room, full, push, pop, wr_en;
    assign free    = LW'(FIFO_DEPTH) - level;
    assign room    = free > LW'(STOP_MARGIN);
    assign full    = level == LW'(FIFO_DEPTH);
    assign push    = !rd_n && !rxf_n;
    assign pop     = m_valid && m_ready;
    assign wr_en   = push && (!full || pop);
    assign m_valid = level > LW'(push_q);
    assign {m_be, m_data} = mem[rd_ptr];
    assign busy    = state != IDLE;
    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE ? (!rxf_n && room ? OE : IDLE) :
                   state == OE   ? (rxf_n ? IDLE : READ) :
                   state == READ ? (rxf_n || !room ? IDLE : READ) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            oe_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            push_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            oe_n     <= state_nx == IDLE;
            rd_n     <= state_nx != READ;
            push_q   <= wr_en;
            level    <= level + LW'(wr_en) - LW'(pop);
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {be_in, data_in};
    end
`ifdef RX_PATTERN_CHECK_EN
    logic [DATA_W-1:0] exp;
    logic seen;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
            exp     <= '0;
            seen    <= 1'b0;
        end else if (push) begin
            seen <= 1'b1;
            exp  <= data_in + 1'b1;
            if (seen && data_in != exp && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ft_rx_fsm.sv
// tb_ft_rx_fsm: directed bench for ft_rx_fsm with a host FIFO model; RX_PATTERN_CHECK_EN enables the err_cnt test
module tb_ft_rx_fsm;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic rxf_n = 1'b1, m_ready = 1'b0, oe_n, rd_n, m_valid, overflow, busy;
    logic [7:0] data_in = '0, m_data;
    logic [1:0] be_in = '0, m_be;
    logic [4:0] level;
    logic b_rxf_n = 1'b1, b_m_ready = 1'b0, b_oe_n, b_rd_n, b_m_valid, b_overflow, b_busy;
    logic [7:0] b_data_in = '0, b_m_data;
    logic [1:0] b_be_in = '0, b_m_be;
    logic [4:0] b_level;
`ifdef RX_PATTERN_CHECK_EN
    logic [15:0] err_cnt, b_err_cnt;
`endif
    logic [9:0] hq[$], got[$], bq[$], bgot[$];
    logic hold = 1'b0;
    int n_chk = 0, n_pass = 0;

    ft_rx_fsm dut (
        .clk(clk), .rst(rst), .rxf_n(rxf_n), .data_in(data_in), .be_in(be_in),
        .oe_n(oe_n), .rd_n(rd_n), .m_data(m_data), .m_be(m_be), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .overflow(overflow),
`ifdef RX_PATTERN_CHECK_EN
        .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    ft_rx_fsm #(.STOP_MARGIN(0)) dut_b (
        .clk(clk), .rst(rst), .rxf_n(b_rxf_n), .data_in(b_data_in), .be_in(b_be_in),
        .oe_n(b_oe_n), .rd_n(b_rd_n), .m_data(b_m_data), .m_be(b_m_be), .m_valid(b_m_valid),
        .m_ready(b_m_ready), .level(b_level), .overflow(b_overflow),
`ifdef RX_PATTERN_CHECK_EN
        .err_cnt(b_err_cnt),
`endif
        .busy(b_busy)
    );

    function automatic logic [9:0] w(input logic [7:0] v);
        return {~v[1:0], v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, req);
    endtask

    task automatic cyc();
        rxf_n = hold || hq.size() == 0;
        {be_in, data_in} = hq.size() != 0 ? hq[0] : 10'h0;
        b_rxf_n = bq.size() == 0;
        {b_be_in, b_data_in} = bq.size() != 0 ? bq[0] : 10'h0;
        if (!rd_n && !rxf_n) hq.delete(0);
        if (!b_rd_n && !b_rxf_n) bq.delete(0);
        if (m_valid && m_ready) got.push_back({m_be, m_data});
        if (b_m_valid && b_m_ready) bgot.push_back({b_m_be, b_m_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst oe_n", oe_n, 1);
        chk("rst rd_n", rd_n, 1);
        chk("rst m_valid", m_valid, 0);
        chk("rst level", level, 0);
        chk("rst overflow", overflow, 0);
        chk("rst busy", busy, 0);

        for (int i = 0; i < 10; i++) hq.push_back(w(8'(i)));
        m_ready = 1'b1;
        cyc();
        chk("t1 oe fall", oe_n, 0);
        chk("t1 rd hold", rd_n, 1);
        chk("t1 busy", busy, 1);
        cyc();
        chk("t1 rd fall", rd_n, 0);
        chk("t1 oe low", oe_n, 0);
        cyc();
        chk("t1 level1", level, 1);
        chk("t1 not yet valid", m_valid, 0);
        cyc();
        chk("t1 valid", m_valid, 1);
        chk("t1 head", {m_be, m_data}, w(8'h00));
        for (int i = 0; i < 40 && !rxf_n; i++) cyc();
        chk("t1 rxf rose", rxf_n, 1);
        chk("t1 oe high", oe_n, 1);
        chk("t1 rd high", rd_n, 1);
        repeat (4) cyc();
        chk("t1 count", got.size(), 10);
        for (int i = 0; i < 10; i++) chk("t1 word", got.size() > i ? got[i] : 10'h3ff, w(8'(i)));
        chk("t1 empty", level, 0);

        got.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) hq.push_back(w(8'(32 + i)));
        repeat (25) cyc();
        chk("t2 level", level, 14);
        chk("t2 idle", busy, 0);
        chk("t2 oe high", oe_n, 1);
        chk("t2 overflow", overflow, 0);
        chk("t2 head", {m_be, m_data}, w(8'h20));
        m_ready = 1'b1;
        cyc();
        chk("t2 level13", level, 13);
        chk("t2 idle13", busy, 0);
        cyc();
        chk("t2 level12", level, 12);
        chk("t2 idle12", busy, 0);
        m_ready = 1'b0;
        cyc();
        chk("t2 restart", busy, 1);
        chk("t2 restart oe", oe_n, 0);
        chk("t2 restart rd", rd_n, 1);

        hold = 1'b1;
        cyc();
        chk("t3 oe high", oe_n, 1);
        chk("t3 rd high", rd_n, 1);
        chk("t3 idle", busy, 0);
        chk("t3 no capture", level, 12);

        m_ready = 1'b1;
        repeat (20) cyc();
        chk("t4 drained", level, 0);
        hq.delete();
        got.delete();
        hold = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) hq.push_back(w(8'(64 + i)));
        repeat (7) cyc();
        chk("t4 level5", level, 5);
        chk("t4 reading", rd_n, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t4 oe high", oe_n, 1);
        chk("t4 rd high", rd_n, 1);
        chk("t4 level0", level, 0);
        chk("t4 m_valid", m_valid, 0);
        chk("t4 idle", busy, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 80 && hq.size() != 0; i++) cyc();
        repeat (4) cyc();
        chk("t4 count", got.size(), 14);
        for (int i = 0; i < 14; i++) chk("t4 word", got.size() > i ? got[i] : 10'h3ff, w(8'(70 + i)));

        for (int i = 0; i < 20; i++) bq.push_back(w(8'(96 + i)));
        repeat (30) cyc();
        chk("t5 overflow", b_overflow, 1);
        chk("t5 level", b_level, 16);
        chk("t5 idle", b_busy, 0);
        chk("t5 strobed", bq.size(), 3);
        b_m_ready = 1'b1;
        repeat (30) cyc();
        chk("t5 sticky", b_overflow, 1);
        chk("t5 count", bgot.size(), 19);
        for (int i = 0; i < 16; i++) chk("t5 word", bgot.size() > i ? bgot[i] : 10'h3ff, w(8'(96 + i)));
        chk("t5 after drop", bgot.size() > 16 ? bgot[16] : 10'h3ff, w(8'h71));

`ifdef RX_PATTERN_CHECK_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6 rst err_cnt", err_cnt, 0);
        hq.push_back(w(8'hFE));
        hq.push_back(w(8'hFF));
        hq.push_back(w(8'h00));
        hq.push_back(w(8'h05));
        hq.push_back(w(8'h06));
        for (int i = 0; i < 40 && hq.size() != 0; i++) cyc();
        repeat (3) cyc();
        chk("t6 err_cnt", err_cnt, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
